// File: rtl/ft_tx_scheduler_pkg.sv
// ft_pkg: shared definitions for the FT600 transmit scheduler.
//   - frame word counts for packet and status frames
//   - packet-frame delimiter byte
//   - scheduler state encoding and grant-source enum
//   - frame builders used by the top level when a source is granted
package ft_pkg;

  localparam int unsigned PKT_WORDS  = 8;
  localparam int unsigned STAT_WORDS = 6;
  localparam int unsigned CNT_W      = 4;

  localparam logic [7:0] PKT_DELIM = 8'h7C;

  // Legacy state encodings kept so existing decoders of the state field still match.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_STAT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_PKT  = ST_PKT,
    S_STAT = ST_STAT
  } ft_state_e;

  typedef enum logic {
    SRC_PKT  = 1'b0,
    SRC_STAT = 1'b1
  } ft_src_e;

  typedef logic [PKT_WORDS-1:0][15:0] ft_frame_t;

  function automatic ft_frame_t build_pkt_frame(input logic [87:0] data,
                                                input logic [15:0] magic,
                                                input logic [15:0] seq);
    ft_frame_t f;
    f    = '0;
    f[0] = data[15:0];
    f[1] = data[31:16];
    f[2] = data[47:32];
    f[3] = data[63:48];
    f[4] = data[79:64];
    f[5] = {PKT_DELIM, data[87:80]};
    f[6] = magic;
    f[7] = seq;
    return f;
  endfunction

  function automatic ft_frame_t build_stat_frame(input logic [15:0] hdr,
                                                 input logic [31:0] total,
                                                 input logic [31:0] mismatch,
                                                 input logic [15:0] seq);
    ft_frame_t f;
    f    = '0;
    f[0] = hdr;
    f[1] = total[15:0];
    f[2] = total[31:16];
    f[3] = mismatch[15:0];
    f[4] = mismatch[31:16];
    f[5] = seq;
    return f;
  endfunction

endpackage

// File: rtl/ft_tx_scheduler_if.sv
// ft_tx_scheduler_if: FT600 transmit FIFO write bus.
//   ui_din        word to the FT TX FIFO
//   ui_din_be     byte enables (always 2'b11)
//   ui_din_valid  ui_din holds a word
//   ui_din_full   FT TX FIFO full; the word is consumed when valid && !full
// master: the scheduler side, slave: the FIFO side.
interface ft_tx_scheduler_if;

  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic        ui_din_full;

  modport master (
    output ui_din,
    output ui_din_be,
    output ui_din_valid,
    input  ui_din_full
  );

  modport slave (
    input  ui_din,
    input  ui_din_be,
    input  ui_din_valid,
    output ui_din_full
  );

endinterface

// File: rtl/ft_tx_scheduler_serializer.sv
// ft_word_serializer: walks a parallel frame register out as 16-bit words.
//   clk_128M, rst_n  clock, async active-low reset
//   load             start a frame; first word is valid in the next cycle
//   frame            frame register (word 0 first), stable for the whole frame
//   nwords           number of words in the frame (1..PKT_WORDS)
//   ft               FT TX bus (master side)
//   done             the last word is being consumed this cycle
module ft_word_serializer
  import ft_pkg::*;
(
  input  logic                   clk_128M,
  input  logic                   rst_n,
  input  logic                   load,
  input  ft_frame_t              frame,
  input  logic [CNT_W-1:0]       nwords,
  ft_tx_scheduler_if.master      ft,
  output logic                   done
);

  logic [2:0] idx_q;
  logic       valid_q;
  logic       consume;
  logic       last_word;

  assign consume   = valid_q && !ft.ui_din_full;
  assign last_word = ({1'b0, idx_q} == (nwords - 4'd1));
  assign done      = consume && last_word;

  // ui_din is a mux off the frame register, so it holds automatically while
  // the FIFO is full and reads 0 after reset (frame register cleared).
  assign ft.ui_din       = frame[idx_q];
  assign ft.ui_din_be    = 2'b11;
  assign ft.ui_din_valid = valid_q;

  always_ff @(posedge clk_128M or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (consume) begin
      if (last_word) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        idx_q   <= idx_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/ft_tx_scheduler.sv
// ft_tx_scheduler: FT600 transmit sequencer in the clk_128M domain.
// Arbitrates between telemetry packet frames (8 words) and status frames
// (6 words, counter snapshots), then serialises the winner with full
// backpressure onto the FT TX bus.
//   clk_128M, rst_n          clock, async active-low reset
//   pkt_data/pkt_valid       88-bit packet, held until pkt_ready
//   pkt_ready                one-cycle acceptance pulse
//   stat_req                 one-cycle status frame request
//   stat_total/stat_mismatch counters snapshotted at status grant
//   ft                       FT TX bus (ui_din, ui_din_be, ui_din_valid, ui_din_full)
//   pkt_seq/stat_seq         frames started per source
//   busy                     a frame is in progress
module ft_tx_scheduler
  import ft_pkg::*;
#(
  parameter logic [31:0] STAT_PERIOD = 32'd0,
  parameter logic [15:0] MAGIC       = 16'hDEC0,
  parameter logic [15:0] STAT_HDR    = 16'h5354
) (
  input  logic               clk_128M,
  input  logic               rst_n,
  input  logic [87:0]        pkt_data,
  input  logic               pkt_valid,
  output logic               pkt_ready,
  input  logic               stat_req,
  input  logic [31:0]        stat_total,
  input  logic [31:0]        stat_mismatch,
  ft_tx_scheduler_if.master  ft,
  output logic [15:0]        pkt_seq,
  output logic [15:0]        stat_seq,
  output logic               busy
);

  ft_state_e          state_q;
  ft_src_e            last_grant_q;
  logic               stat_pending_q;
  logic [31:0]        period_cnt_q;
  ft_frame_t          frame_q;
  logic [CNT_W-1:0]   nwords_q;
  logic [15:0]        pkt_seq_q;
  logic [15:0]        stat_seq_q;
  logic               pkt_ready_q;

  logic               period_hit;
  logic               grant_pkt;
  logic               grant_stat;
  logic               ser_done;
  logic [15:0]        pkt_seq_nxt;
  logic [15:0]        stat_seq_nxt;

  assign pkt_seq_nxt  = pkt_seq_q + 16'd1;
  assign stat_seq_nxt = stat_seq_q + 16'd1;

  assign period_hit = (STAT_PERIOD != 32'd0) && (period_cnt_q == STAT_PERIOD - 32'd1);

  // Round-robin on ties: last_grant names the loser-to-be. The two grants are
  // mutually exclusive because a tie resolves on last_grant alone.
  assign grant_pkt  = (state_q == S_IDLE) && pkt_valid &&
                      (!stat_pending_q || last_grant_q == SRC_STAT);
  assign grant_stat = (state_q == S_IDLE) && stat_pending_q &&
                      (!pkt_valid || last_grant_q == SRC_PKT);

  always_ff @(posedge clk_128M or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q <= '0;
    end else if (period_hit || STAT_PERIOD == 32'd0) begin
      period_cnt_q <= '0;
    end else begin
      period_cnt_q <= period_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_128M or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_grant_q   <= SRC_STAT;
      stat_pending_q <= 1'b0;
      frame_q        <= '0;
      nwords_q       <= '0;
      pkt_seq_q      <= '0;
      stat_seq_q     <= '0;
      pkt_ready_q    <= 1'b0;
    end else begin
      pkt_ready_q <= grant_pkt;
      // A new request arriving with the grant re-arms pending.
      stat_pending_q <= (stat_pending_q && !grant_stat) || stat_req || period_hit;

      case (state_q)
        S_IDLE: begin
          if (grant_pkt) begin
            state_q      <= S_PKT;
            last_grant_q <= SRC_PKT;
            pkt_seq_q    <= pkt_seq_nxt;
            frame_q      <= build_pkt_frame(pkt_data, MAGIC, pkt_seq_nxt);
            nwords_q     <= CNT_W'(PKT_WORDS);
          end else if (grant_stat) begin
            state_q      <= S_STAT;
            last_grant_q <= SRC_STAT;
            stat_seq_q   <= stat_seq_nxt;
            frame_q      <= build_stat_frame(STAT_HDR, stat_total, stat_mismatch, stat_seq_nxt);
            nwords_q     <= CNT_W'(STAT_WORDS);
          end
        end
        S_PKT, S_STAT: begin
          if (ser_done) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  ft_word_serializer u_serializer (
    .clk_128M (clk_128M),
    .rst_n    (rst_n),
    .load     (grant_pkt || grant_stat),
    .frame    (frame_q),
    .nwords   (nwords_q),
    .ft       (ft),
    .done     (ser_done)
  );

  assign pkt_ready = pkt_ready_q;
  assign pkt_seq   = pkt_seq_q;
  assign stat_seq  = stat_seq_q;
  assign busy      = (state_q != S_IDLE);

endmodule
